link_monitor: RTL and testbench

- Supervises the board-to-board UART link for two-player mode.
- Sits between the UART receive path (the byte stream feeding uart_decoder) and game_state_sel / the TX byte arbiter.
- Periodically requests a heartbeat byte for transmission and checks incoming heartbeats for sequence continuity and timeout.
- Produces the debounced link-up flag used for conn_led and the game-state logic.

---
 rtl/link_monitor_pkg.sv | 18 +
 rtl/link_timer.sv | 37 +++
 rtl/link_monitor.sv | 177 +++++++++++++++++
 tb/tb_link_monitor.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_monitor_pkg.sv
// Shared types and helpers for the board-to-board link supervisor.
// Optional statistics output is enabled with LINK_MONITOR_STATS_EN (see link_monitor).
package link_monitor_pkg;

    typedef enum logic [1:0] {
        DISCONNECTED = 2'd0,
        SYNCING      = 2'd1,
        CONNECTED    = 2'd2,
        LOST         = 2'd3
    } link_state_t;

    localparam logic [2:0] HB_OPCODE = 3'b111;

    function automatic int ms_to_ticks(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/link_timer.sv
// Enable/clear counter that flags the cycle it reaches LIMIT; either wraps to zero
// (periodic tick) or saturates at LIMIT (silence detector).
module link_timer
    import link_monitor_pkg::*;
#(
    parameter int LIMIT = 10,
    parameter int W     = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic hit
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP  = W'(LIMIT);

    logic [W-1:0] count;

    // Saturated counts keep hit asserted so a held-off timeout is not missed.
    assign hit = en && !clr && (count >= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (hit) begin
            count <= WRAP ? '0 : TOP;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/link_monitor.sv
// Board-to-board UART link supervisor: heartbeat generation, sequence tracking, timeout.
// Define LINK_MONITOR_STATS_EN to add the seq_err_cnt output.
//
//   state        | meaning
//   DISCONNECTED | no link; waiting for any heartbeat
//   SYNCING      | counting consecutive in-sequence heartbeats
//   CONNECTED    | link up; only silence drops it
//   LOST         | one-cycle link_lost pulse, then DISCONNECTED
module link_monitor
    import link_monitor_pkg::*;
#(
    parameter int CLK_HZ       = 65_000_000,
    parameter int HB_PERIOD_MS = 100,
    parameter int TIMEOUT_MS   = 500,
    parameter int LOCK_COUNT   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic       hb_grant,
    output logic       hb_req,
    output logic [7:0] hb_data,
    output logic       connected,
    output logic       link_lost,
    output logic [1:0] link_state
`ifdef LINK_MONITOR_STATS_EN
    ,
    output logic [7:0] seq_err_cnt
`endif
);

    localparam int HB_TICKS = ms_to_ticks(CLK_HZ, HB_PERIOD_MS);
    localparam int TO_TICKS = ms_to_ticks(CLK_HZ, TIMEOUT_MS);
    localparam int HB_W     = $clog2(HB_TICKS + 1);
    localparam int TO_W     = $clog2(TO_TICKS + 1);
    localparam int LOCK_W   = $clog2(LOCK_COUNT + 1);

    logic        hb_hit;
    logic        rx_timeout;
    logic [4:0]  tx_seq;
    logic        hb_rx;
    logic        in_seq;
    logic [4:0]  payload;

    link_state_t       state_q, state_d;
    logic [LOCK_W-1:0] lock_q, lock_d, lock_inc;
    logic [4:0]        exp_q, exp_d;

    // The heartbeat timer is frozen while a byte is pending, so grant and expiry never collide.
    link_timer #(.LIMIT(HB_TICKS), .W(HB_W), .WRAP(1'b1)) u_hb_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable && !hb_req),
        .clr   (!enable),
        .hit   (hb_hit)
    );

    link_timer #(.LIMIT(TO_TICKS), .W(TO_W), .WRAP(1'b0)) u_rx_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (enable),
        .clr   (!enable || rx_valid),
        .hit   (rx_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_req  <= 1'b0;
            hb_data <= 8'h00;
            tx_seq  <= 5'd0;
        end else if (!enable) begin
            hb_req <= 1'b0;
        end else if (hb_req) begin
            if (hb_grant) begin
                hb_req <= 1'b0;
                tx_seq <= tx_seq + 5'd1;
            end
        end else if (hb_hit) begin
            hb_req  <= 1'b1;
            hb_data <= {tx_seq, HB_OPCODE};
        end
    end

    assign payload  = rx_byte[7:3];
    assign hb_rx    = rx_valid && (rx_byte[2:0] == HB_OPCODE);
    assign in_seq   = (payload == exp_q);
    assign lock_inc = lock_q + 1'b1;

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        exp_d   = exp_q;
        if (!enable) begin
            state_d = DISCONNECTED;
            lock_d  = '0;
        end else begin
            case (state_q)
                DISCONNECTED: begin
                    if (hb_rx) begin
                        lock_d  = LOCK_W'(1);
                        exp_d   = payload + 5'd1;
                        state_d = (LOCK_COUNT <= 1) ? CONNECTED : SYNCING;
                    end
                end
                SYNCING: begin
                    if (hb_rx) begin
                        exp_d = payload + 5'd1;
                        if (in_seq) begin
                            lock_d = lock_inc;
                            if (lock_inc >= LOCK_W'(LOCK_COUNT)) begin
                                state_d = CONNECTED;
                            end
                        end else begin
                            lock_d = LOCK_W'(1);
                        end
                    end else if (rx_timeout) begin
                        state_d = DISCONNECTED;
                        lock_d  = '0;
                    end
                end
                CONNECTED: begin
                    if (hb_rx) begin
                        exp_d = payload + 5'd1;
                    end else if (rx_timeout) begin
                        state_d = LOST;
                    end
                end
                LOST: begin
                    state_d = DISCONNECTED;
                    lock_d  = '0;
                end
                default: begin
                    state_d = DISCONNECTED;
                    lock_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DISCONNECTED;
            lock_q    <= '0;
            exp_q     <= 5'd0;
            connected <= 1'b0;
            link_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            exp_q     <= exp_d;
            connected <= (state_d == CONNECTED);
            link_lost <= (state_d == LOST);
        end
    end

    assign link_state = state_q;

`ifdef LINK_MONITOR_STATS_EN
    logic seq_err;

    assign seq_err = enable && hb_rx && !in_seq &&
                     ((state_q == SYNCING) || (state_q == CONNECTED));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err_cnt <= 8'h00;
        end else if (state_q == LOST) begin
            seq_err_cnt <= 8'h00;
        end else if (seq_err && (seq_err_cnt != 8'hFF)) begin
            seq_err_cnt <= seq_err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_link_monitor.sv
// Scoreboard bench for link_monitor: a cycle-level behavioural model predicts outputs,
// a separate monitor compares them; directed scenarios plus randomized traffic.
module tb_link_monitor;

    localparam int CLK_HZ = 1000;
    localparam int HB_MS  = 10;
    localparam int TO_MS  = 50;
    localparam int LOCK   = 3;
    localparam int HB_T   = CLK_HZ / 1000 * HB_MS;
    localparam int TO_T   = CLK_HZ / 1000 * TO_MS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       hb_grant = 1'b0;
    logic       hb_req;
    logic [7:0] hb_data;
    logic       connected;
    logic       link_lost;
    logic [1:0] link_state;
`ifdef LINK_MONITOR_STATS_EN
    logic [7:0] seq_err_cnt;
`endif

    link_monitor #(
        .CLK_HZ       (CLK_HZ),
        .HB_PERIOD_MS (HB_MS),
        .TIMEOUT_MS   (TO_MS),
        .LOCK_COUNT   (LOCK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .hb_grant   (hb_grant),
        .hb_req     (hb_req),
        .hb_data    (hb_data),
        .connected  (connected),
        .link_lost  (link_lost),
        .link_state (link_state)
`ifdef LINK_MONITOR_STATS_EN
        ,
        .seq_err_cnt (seq_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hb_req;
        logic [7:0] hb_data;
        logic       connected;
        logic       link_lost;
        logic [1:0] link_state;
    } exp_t;

    exp_t exp_fifo[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: link phase, consecutive-run length, last payload, silence length.
    int m_state, m_run, m_last, m_sil;
    int m_wait, m_seq, m_data;
    bit m_pend;

    task automatic model_reset();
        m_state = 0; m_run = 0; m_last = 0; m_sil = 0;
        m_wait = 0; m_seq = 0; m_data = 0; m_pend = 0;
    endtask

    task automatic model_step();
        bit hb;
        bit tmo;
        int p;
        if (!enable) begin
            m_pend = 0;
            m_wait = 0;
        end else if (m_pend) begin
            if (hb_grant) begin
                m_pend = 0;
                m_seq  = (m_seq + 1) % 32;
            end
        end else begin
            m_wait++;
            if (m_wait == HB_T) begin
                m_pend = 1;
                m_data = m_seq * 8 + 7;
                m_wait = 0;
            end
        end
        hb = rx_valid && (rx_byte[2:0] == 3'b111);
        p  = int'(rx_byte[7:3]);
        if (!enable || rx_valid) m_sil = 0;
        else m_sil++;
        tmo = enable && (m_sil >= TO_T);
        if (!enable) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (hb) begin
                    m_run = 1; m_last = p;
                    m_state = (LOCK <= 1) ? 2 : 1;
                end
                1: if (hb) begin
                    m_run  = (p == (m_last + 1) % 32) ? m_run + 1 : 1;
                    m_last = p;
                    if (m_run >= LOCK) m_state = 2;
                end else if (tmo) begin
                    m_state = 0;
                end
                2: if (hb) m_last = p;
                   else if (tmo) m_state = 3;
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.hb_req     = m_pend;
        e.hb_data    = 8'(m_data);
        e.connected  = (m_state == 2);
        e.link_lost  = (m_state == 3);
        e.link_state = 2'(m_state);
        return e;
    endfunction

    function automatic logic [7:0] hbyte(input int p);
        logic [4:0] s;
        s = 5'(p);
        return {s, 3'b111};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Called at a falling edge; drives inputs for one rising edge and queues the prediction.
    task automatic tick(input bit v, input logic [7:0] b, input bit g);
        rx_valid = v;
        rx_byte  = b;
        hb_grant = g;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        exp_fifo.push_back(model_out());
        @(negedge clk);
        rx_valid = 1'b0;
        hb_grant = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_fifo.size() > 0) begin
                e = exp_fifo.pop_front();
                a = {hb_req, hb_data, connected, link_lost, link_state};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got req=%b data=%h con=%b lost=%b st=%0d exp req=%b data=%h con=%b lost=%b st=%0d",
                             $time, a.hb_req, a.hb_data, a.connected, a.link_lost, a.link_state,
                             e.hb_req, e.hb_data, e.connected, e.link_lost, e.link_state);
                end
            end
        end
    end

    initial begin
        int n;
        int sp;
        int r;
        bit v;
        bit g;
        logic [7:0] b;
        model_reset();
        @(negedge clk);
        idle(2);
        check("reset_outputs", int'({hb_req, hb_data, connected, link_lost, link_state}), 0);

        // 1: heartbeat transmit timing and grant handshake
        rst_n = 1'b1;
        enable = 1'b1;
        n = 0;
        while (!hb_req && n < 100) begin idle(1); n++; end
        check("hb_first_delay", n, HB_T);
        check("hb_first_data", int'(hb_data), 8'h07);
        idle(9);
        check("hb_hold_req", int'(hb_req), 1);
        tick(1'b0, 8'h00, 1'b1);
        check("hb_grant_clears", int'(hb_req), 0);
        n = 0;
        while (!hb_req && n < 100) begin idle(1); n++; end
        check("hb_second_delay", n, HB_T);
        check("hb_second_data", int'(hb_data), 8'h0F);

        // 2: lock on 5,6,7
        tick(1'b1, 8'h2F, 1'b0);
        check("sync_after_5", int'(link_state), 1);
        idle(4);
        tick(1'b1, 8'h37, 1'b0);
        check("sync_after_6", int'(link_state), 1);
        idle(4);
        tick(1'b1, 8'h3F, 1'b0);
        check("conn_after_7", int'({connected, link_state}), 6);

        // 3: disable drops link silently, then 5,9,10,11 relock
        enable = 1'b0;
        idle(1);
        check("disable_no_lost", int'({connected, link_lost, link_state}), 0);
        enable = 1'b1;
        tick(1'b1, hbyte(5), 1'b0);
        idle(2);
        tick(1'b1, hbyte(9), 1'b0);
        idle(2);
        tick(1'b1, hbyte(10), 1'b0);
        check("resync_not_conn", int'({connected, link_state}), 1);
        idle(2);
        tick(1'b1, hbyte(11), 1'b0);
        check("resync_conn", int'({connected, link_state}), 6);

        // 4: silence timeout
        n = 0;
        while (!link_lost && n < 200) begin idle(1); n++; end
        check("timeout_delay", n, TO_T);
        check("lost_state", int'({connected, link_state}), 3);
        idle(1);
        check("lost_one_cycle", int'({link_lost, link_state}), 0);

        // 5: sequence wrap on both sides
        n = 0;
        while (n < 1000 && !(hb_req && hb_data == 8'hFF)) begin tick(1'b0, 8'h00, hb_req); n++; end
        check("wrap_reach_31", int'(hb_data), 8'hFF);
        tick(1'b0, 8'h00, 1'b1);
        n = 0;
        while (!hb_req && n < 100) begin idle(1); n++; end
        check("wrap_data", int'(hb_data), 8'h07);
        tick(1'b1, hbyte(30), 1'b0);
        idle(3);
        tick(1'b1, hbyte(31), 1'b0);
        idle(3);
        tick(1'b1, hbyte(0), 1'b0);
        check("rx_wrap_conn", int'(connected), 1);

        // 6: async reset mid-SYNCING with a pending heartbeat
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        tick(1'b1, hbyte(4), 1'b0);
        n = 0;
        while (!hb_req && n < 100) begin idle(1); n++; end
        check("pre_rst_state", int'({hb_req, link_state}), 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", int'({hb_req, hb_data, connected, link_lost, link_state}), 0);
        @(negedge clk);
        idle(1);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(1'b1, hbyte(i), 1'b0);
            idle(2);
        end
        check("reconn", int'(connected), 1);
        enable = 1'b0;
        idle(1);
        check("disable_conn", int'({connected, link_lost}), 0);
        idle(1);
        check("disable_no_pulse", int'(link_lost), 0);
        enable = 1'b1;

        // Randomized traffic
        sp = $urandom_range(0, 31);
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 2) begin
                enable = 1'b0;
                idle($urandom_range(1, 5));
                enable = 1'b1;
            end else if (r < 6) begin
                idle(TO_T + 10);
            end else begin
                v = 1'b0;
                b = 8'h00;
                if ($urandom_range(0, 5) == 0) begin
                    v = 1'b1;
                    if ($urandom_range(0, 9) < 7) begin
                        b  = hbyte(sp);
                        sp = (sp + 1) % 32;
                    end else if ($urandom_range(0, 1) == 1) begin
                        b = hbyte($urandom_range(0, 31));
                    end else begin
                        b = {5'($urandom_range(0, 31)), 3'($urandom_range(0, 6))};
                    end
                end
                g = hb_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
                tick(v, b, g);
            end
        end
        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
